mod_addsub_bist: RTL and testbench

Hardware built-in self-test engine for the 4-bit modular adder/subtractor (`MAIN`). It drives the adder's `s`, `x3..x0` and `y3..y0` inputs and checks its `z3..z0` outputs. One run sweeps every legal vector (s ∈ {0,1}, x, y ∈ [0, m−1]) and compares each result against an internally computed reference. It reports the pass count and the first failing vector. It sits beside `MAIN` in the top level and replaces simulation-only checking on the board.

---
 rtl/mod_addsub_bist.sv | 190 +++++++++++++++++++
 tb/tb_mod_addsub_bist.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_bist.sv
// Built-in self-test engine for the 4-bit modular adder/subtractor: sweeps every
// legal (s, x, y) vector, checks z against a reference and records the first failure.
module mod_addsub_bist #(
    parameter logic [3:0] m = 4'b1111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       s,
    output logic       x3,
    output logic       x2,
    output logic       x1,
    output logic       x0,
    output logic       y3,
    output logic       y2,
    output logic       y1,
    output logic       y0,
    input  logic       z3,
    input  logic       z2,
    input  logic       z1,
    input  logic       z0,
    output logic       busy,
    output logic       done,
    output logic [8:0] pass_count,
    output logic [8:0] total,
    output logic       all_pass,
    output logic       fail_valid,
    output logic       fail_s,
    output logic [3:0] fail_x,
    output logic [3:0] fail_y,
    output logic [3:0] fail_z
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] last_c  = m - 4'd1;
    localparam logic [8:0] total_c = 9'(2 * int'(m) * int'(m));

    state_t     state_q, state_d;
    logic       s_q, s_d;
    logic [3:0] x_q, x_d;
    logic [3:0] y_q, y_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [8:0] pass_count_q, pass_count_d;
    logic       fail_valid_q, fail_valid_d;
    logic       fail_s_q, fail_s_d;
    logic [3:0] fail_x_q, fail_x_d;
    logic [3:0] fail_y_q, fail_y_d;
    logic [3:0] fail_z_q, fail_z_d;

    logic [3:0] z_w;
    logic [4:0] sum_w;
    logic [4:0] diff_w;
    logic [4:0] exp_w;
    logic       match_w;
    logic       last_vec_w;

    assign z_w = {z3, z2, z1, z0};

    // Reference result for the vector currently driven; 5 bits so x + y never wraps.
    always_comb begin
        sum_w  = {1'b0, x_q} + {1'b0, y_q};
        diff_w = {1'b0, x_q} - {1'b0, y_q};
        if (!s_q) begin
            exp_w = (sum_w >= {1'b0, m}) ? sum_w - {1'b0, m} : sum_w;
        end else begin
            exp_w = (x_q >= y_q) ? diff_w : diff_w + {1'b0, m};
        end
        match_w    = (exp_w == {1'b0, z_w});
        last_vec_w = s_q && (x_q == last_c) && (y_q == last_c);
    end

    always_comb begin
        // NOTE: every _d takes its _q value first so no path through this block infers a latch.
        state_d      = state_q;
        s_d          = s_q;
        x_d          = x_q;
        y_d          = y_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_count_d = pass_count_q;
        fail_valid_d = fail_valid_q;
        fail_s_d     = fail_s_q;
        fail_x_d     = fail_x_q;
        fail_y_d     = fail_y_q;
        fail_z_d     = fail_z_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    s_d          = 1'b0;
                    x_d          = 4'd0;
                    y_d          = 4'd0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_count_d = 9'd0;
                    fail_valid_d = 1'b0;
                    fail_s_d     = 1'b0;
                    fail_x_d     = 4'd0;
                    fail_y_d     = 4'd0;
                    fail_z_d     = 4'd0;
                end
            end
            RUN: begin
                if (match_w) begin
                    pass_count_d = pass_count_q + 9'd1;
                end else if (!fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    fail_s_d     = s_q;
                    fail_x_d     = x_q;
                    fail_y_d     = y_q;
                    fail_z_d     = z_w;
                end

                // y innermost, then x, then s; the final subtract vector ends the sweep.
                if (last_vec_w) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    s_d     = 1'b0;
                    x_d     = 4'd0;
                    y_d     = 4'd0;
                end else if (y_q == last_c) begin
                    y_d = 4'd0;
                    if (x_q == last_c) begin
                        x_d = 4'd0;
                        s_d = 1'b1;
                    end else begin
                        x_d = x_q + 4'd1;
                    end
                end else begin
                    y_d = y_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
        if (!rst_n) begin
            state_q      <= IDLE;
            s_q          <= 1'b0;
            x_q          <= 4'd0;
            y_q          <= 4'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_count_q <= 9'd0;
            fail_valid_q <= 1'b0;
            fail_s_q     <= 1'b0;
            fail_x_q     <= 4'd0;
            fail_y_q     <= 4'd0;
            fail_z_q     <= 4'd0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            x_q          <= x_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_count_q <= pass_count_d;
            fail_valid_q <= fail_valid_d;
            fail_s_q     <= fail_s_d;
            fail_x_q     <= fail_x_d;
            fail_y_q     <= fail_y_d;
            fail_z_q     <= fail_z_d;
        end
    end

    assign s                = s_q;
    assign {x3, x2, x1, x0} = x_q;
    assign {y3, y2, y1, y0} = y_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass_count       = pass_count_q;
    assign total            = total_c;
    assign all_pass         = done_q && (pass_count_q == total_c);
    assign fail_valid       = fail_valid_q;
    assign fail_s           = fail_s_q;
    assign fail_x           = fail_x_q;
    assign fail_y           = fail_y_q;
    assign fail_z           = fail_z_q;

endmodule

// File: tb/tb_mod_addsub_bist.sv
// Bench for mod_addsub_bist: two instances (m = 15 and m = 9) each wired to a
// behavioural modular adder; the driven vector sequence is checked through a scoreboard queue.
module tb_mod_addsub_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start15, start9;
    logic zero_mode;
    logic sel9;

    int n_cmp = 0;
    int n_bad = 0;

    wire        s15, s9;
    wire  [3:0] x15, y15, x9, y9;
    logic [3:0] z15, z9;
    wire        busy15, done15, all15, fv15, fs15, busy9, done9, all9, fv9, fs9;
    wire  [8:0] pass15, total15, pass9, total9;
    wire  [3:0] fx15, fy15, fz15, fx9, fy9, fz9;

    mod_addsub_bist #(.m(4'd15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .start(start15), .s(s15),
        .x3(x15[3]), .x2(x15[2]), .x1(x15[1]), .x0(x15[0]),
        .y3(y15[3]), .y2(y15[2]), .y1(y15[1]), .y0(y15[0]),
        .z3(z15[3]), .z2(z15[2]), .z1(z15[1]), .z0(z15[0]),
        .busy(busy15), .done(done15), .pass_count(pass15), .total(total15),
        .all_pass(all15), .fail_valid(fv15), .fail_s(fs15),
        .fail_x(fx15), .fail_y(fy15), .fail_z(fz15)
    );

    mod_addsub_bist #(.m(4'd9)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .start(start9), .s(s9),
        .x3(x9[3]), .x2(x9[2]), .x1(x9[1]), .x0(x9[0]),
        .y3(y9[3]), .y2(y9[2]), .y1(y9[1]), .y0(y9[0]),
        .z3(z9[3]), .z2(z9[2]), .z1(z9[1]), .z0(z9[0]),
        .busy(busy9), .done(done9), .pass_count(pass9), .total(total9),
        .all_pass(all9), .fail_valid(fv9), .fail_s(fs9),
        .fail_x(fx9), .fail_y(fy9), .fail_z(fz9)
    );

    // Behavioural MAIN: plain integer modulo arithmetic.
    function automatic logic [3:0] main_model(input logic op, input logic [3:0] a, input logic [3:0] b,
                                              input int md);
        int r;
        if (!op) r = (int'(a) + int'(b)) % md;
        else     r = (int'(a) - int'(b) + md) % md;
        return 4'(r);
    endfunction

    always_comb begin
        z15 = zero_mode ? 4'd0 : main_model(s15, x15, y15, 15);
        z9  = main_model(s9, x9, y9, 9);
    end

    // View of whichever instance is under test.
    logic       o_s, o_busy, o_done, o_all, o_fv;
    logic [3:0] o_x, o_y;
    logic [8:0] o_pass;
    always_comb begin
        o_s    = sel9 ? s9    : s15;
        o_x    = sel9 ? x9    : x15;
        o_y    = sel9 ? y9    : y15;
        o_busy = sel9 ? busy9 : busy15;
        o_done = sel9 ? done9 : done15;
        o_all  = sel9 ? all9  : all15;
        o_fv   = sel9 ? fv9   : fv15;
        o_pass = sel9 ? pass9 : pass15;
    end

    typedef struct {
        int         edges;
        int         vec_errs;
        bit         timeout;
        logic       done0;
        logic       busy0;
        logic [8:0] pass0;
        logic       fail0;
    } run_t;

    logic [8:0] exp_vec_q[$];

    task automatic drive_start(input logic v);
        start15 = v & !sel9;
        start9  = v & sel9;
    endtask

    // Pulses start, pops one expected vector per RUN cycle, and counts edges until done.
    task automatic run_to_done(input int md, input int poke_at, output run_t r);
        logic [8:0] exp_v;
        int n;
        exp_vec_q.delete();
        for (int so = 0; so < 2; so++)
            for (int xi = 0; xi < md; xi++)
                for (int yi = 0; yi < md; yi++)
                    exp_vec_q.push_back({1'(so), 4'(xi), 4'(yi)});
        r.vec_errs = 0;
        @(negedge clk); drive_start(1'b1);
        @(negedge clk); drive_start(1'b0);
        r.done0 = o_done; r.busy0 = o_busy; r.pass0 = o_pass; r.fail0 = o_fv;
        n = 0;
        while (!o_done && n < 2000) begin
            if (!o_busy || exp_vec_q.size() == 0) begin
                r.vec_errs++;
            end else begin
                exp_v = exp_vec_q.pop_front();
                if ({o_s, o_x, o_y} !== exp_v) r.vec_errs++;
            end
            drive_start(n == poke_at);
            @(negedge clk);
            drive_start(1'b0);
            n++;
        end
        r.timeout = !o_done;
        r.edges   = n;
        r.vec_errs += exp_vec_q.size();
    endtask

    task automatic check_clean_sweep(input string tag, input int md, input run_t r);
        int tot;
        tot = 2 * md * md;
        n_cmp++; if (r.timeout)           begin n_bad++; $display("FAIL %s timeout: done never rose", tag); end
        n_cmp++; if (r.edges !== tot)     begin n_bad++; $display("FAIL %s done_edge: got %0d want %0d", tag, r.edges, tot); end
        n_cmp++; if (r.vec_errs !== 0)    begin n_bad++; $display("FAIL %s vector_order: %0d bad vectors want 0", tag, r.vec_errs); end
        n_cmp++; if (o_pass !== 9'(tot))  begin n_bad++; $display("FAIL %s pass_count: got %0d want %0d", tag, o_pass, tot); end
        n_cmp++; if ({o_busy, o_all, o_fv} !== 3'b010) begin n_bad++; $display("FAIL %s busy/all_pass/fail_valid: got %b want 010", tag, {o_busy, o_all, o_fv}); end
        n_cmp++; if ({o_s, o_x, o_y} !== 9'd0) begin n_bad++; $display("FAIL %s operands_after_done: got %h want 0", tag, {o_s, o_x, o_y}); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drive_start(1'b0);
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy15, done15, fv15, s15, x15, y15} !== 12'd0) begin n_bad++; $display("FAIL reset_ctrl: got %h want 0", {busy15, done15, fv15, s15, x15, y15}); end
        n_cmp++; if ({pass15, fs15, fx15, fy15, fz15} !== 22'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", {pass15, fs15, fx15, fy15, fz15}); end
        n_cmp++; if (total15 !== 9'd450) begin n_bad++; $display("FAIL total15: got %0d want 450", total15); end
        n_cmp++; if (total9 !== 9'd162)  begin n_bad++; $display("FAIL total9: got %0d want 162", total9); end
        n_cmp++; if (all15 !== 1'b0)     begin n_bad++; $display("FAIL reset_all_pass: got %b want 0", all15); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_sweep();
        run_t r;
        sel9 = 1'b0; zero_mode = 1'b0;
        run_to_done(15, -1, r);
        n_cmp++; if ({r.busy0, r.done0} !== 2'b10) begin n_bad++; $display("FAIL first_cycle busy/done: got %b want 10", {r.busy0, r.done0}); end
        check_clean_sweep("full15", 15, r);
        repeat (5) @(negedge clk);
        n_cmp++; if ({o_done, o_pass} !== {1'b1, 9'd450}) begin n_bad++; $display("FAIL done_hold: got done=%b pass=%0d want 1/450", o_done, o_pass); end
    endtask

    task automatic test_restart_from_done();
        run_t r;
        run_to_done(15, -1, r);
        n_cmp++; if ({r.done0, r.pass0} !== 10'd0) begin n_bad++; $display("FAIL restart_clear: got done=%b pass=%0d want 0/0", r.done0, r.pass0); end
        check_clean_sweep("restart", 15, r);
    endtask

    task automatic test_z_zero();
        run_t r;
        zero_mode = 1'b1;
        run_to_done(15, -1, r);
        zero_mode = 1'b0;
        n_cmp++; if (r.edges !== 450)     begin n_bad++; $display("FAIL zz_done_edge: got %0d want 450", r.edges); end
        n_cmp++; if (pass15 !== 9'd30)    begin n_bad++; $display("FAIL zz_pass_count: got %0d want 30", pass15); end
        n_cmp++; if ({fv15, all15} !== 2'b10) begin n_bad++; $display("FAIL zz_fail_valid/all_pass: got %b want 10", {fv15, all15}); end
        n_cmp++; if ({fs15, fx15, fy15, fz15} !== {1'b0, 4'd0, 4'd1, 4'd0}) begin n_bad++; $display("FAIL zz_fail_vector: got s=%b x=%0d y=%0d z=%0d want 0/0/1/0", fs15, fx15, fy15, fz15); end
    endtask

    task automatic test_start_ignored();
        run_t r;
        run_to_done(15, 50, r);
        n_cmp++; if (r.fail0 !== 1'b0) begin n_bad++; $display("FAIL start_clears_fail: got %b want 0", r.fail0); end
        check_clean_sweep("start_ignored", 15, r);
    endtask

    task automatic test_reset_mid_run();
        run_t r;
        @(negedge clk); drive_start(1'b1);
        @(negedge clk); drive_start(1'b0);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({busy15, done15, fv15, s15, x15, y15, pass15} !== 21'd0) begin n_bad++; $display("FAIL midrun_reset: got %h want 0", {busy15, done15, fv15, s15, x15, y15, pass15}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy15 !== 1'b0) begin n_bad++; $display("FAIL midrun_idle: busy got %b want 0", busy15); end
        run_to_done(15, -1, r);
        check_clean_sweep("after_reset", 15, r);
    endtask

    task automatic test_m9();
        run_t r;
        sel9 = 1'b1;
        run_to_done(9, -1, r);
        check_clean_sweep("m9", 9, r);
        n_cmp++; if (total9 !== 9'd162) begin n_bad++; $display("FAIL m9_total: got %0d want 162", total9); end
        sel9 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start15 = 1'b0; start9 = 1'b0; zero_mode = 1'b0; sel9 = 1'b0;
        test_reset();
        test_full_sweep();
        test_restart_from_done();
        test_z_zero();
        test_start_ignored();
        test_reset_mid_run();
        test_m9();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
